// File: rtl/udp_receive_package.sv
// -----------------------------------------------------------------------------
// udp_receive_package
// Shared definitions for the UDP receive dispatcher and its slot selector:
// the dispatcher FSM state encoding, the default slot count and a helper
// that turns a one-hot slot grant into a slot index.
// -----------------------------------------------------------------------------
package udp_receive_package;

  localparam int SLOT_COUNT_DEFAULT = 4;

  // Wide enough for the largest supported slot count (8).
  localparam int SLOT_INDEX_WIDTH = 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FORWARD = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  // Index of the set bit of a one-hot vector (zero when no bit is set).
  function automatic logic [SLOT_INDEX_WIDTH-1:0] onehot_to_index(input logic [7:0] onehot);
    logic [SLOT_INDEX_WIDTH-1:0] index;
    index = '0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) index = SLOT_INDEX_WIDTH'(i);
    end
    return index;
  endfunction

endpackage

// File: rtl/round_robin_selector.sv
// -----------------------------------------------------------------------------
// round_robin_selector
// Combinational round-robin arbiter. Searches the request vector starting one
// above the last granted index (pointer_i) and wrapping modulo SLOT_COUNT.
// Ports:
//   request_i     - per-slot request (ready and eligible)
//   pointer_i     - index of the most recently granted slot
//   grant_o       - one-hot grant, zero when nothing is requested
//   grant_valid_o - high when grant_o has a bit set
// -----------------------------------------------------------------------------
module round_robin_selector
  import udp_receive_package::*;
#(
  parameter int SLOT_COUNT = SLOT_COUNT_DEFAULT
) (
  input  logic [SLOT_COUNT-1:0]       request_i,
  input  logic [SLOT_INDEX_WIDTH-1:0] pointer_i,
  output logic [SLOT_COUNT-1:0]       grant_o,
  output logic                        grant_valid_o
);

  logic [SLOT_INDEX_WIDTH-1:0] shift;
  logic [SLOT_COUNT-1:0]       rotated;
  logic                        found;
  int                          win;
  int                          absolute;

  // Rotating the doubled request puts the search start at bit 0. The 3-bit
  // wrap of pointer+1 only happens at pointer 7, where 0 is the right start.
  assign shift   = pointer_i + SLOT_INDEX_WIDTH'(1);
  assign rotated = SLOT_COUNT'({request_i, request_i} >> shift);

  always_comb begin
    found    = 1'b0;
    win      = 0;
    absolute = 0;
    grant_o  = '0;
    for (int k = 0; k < SLOT_COUNT; k++) begin
      if (!found && rotated[k]) begin
        found = 1'b1;
        win   = k;
      end
    end
    absolute = (int'(pointer_i) + 1 + win) % SLOT_COUNT;
    for (int i = 0; i < SLOT_COUNT; i++) begin
      if (found && absolute == i) grant_o[i] = 1'b1;
    end
    grant_valid_o = found;
  end

endmodule

// File: rtl/udp_receive_dispatcher.sv
// -----------------------------------------------------------------------------
// udp_receive_dispatcher
// Steers UDP payload bytes from the parser to one of SLOT_COUNT receive slots,
// chosen round-robin among ready slots at packet start. Packets with no ready
// slot are discarded and counted.
// Ports:
//   clock, reset_n            - clock, asynchronous active-low reset
//   data, data_valid          - payload byte and qualifier (gaps allowed)
//   packet_start/end/error    - packet markers, qualified by data_valid
//   ipv4_flags/identification - header fields, valid with packet_start
//   slot_ready                - per-slot ready, sampled at packet_start only
//   slot_data/_data_enable    - registered byte and one-hot write enable
//   slot_good/bad_packet      - one-cycle completion pulses per slot
//   slot_ipv4_*               - header fields held for the current packet
//   dropped_packet/drop_count - drop pulse and saturating drop counter
// -----------------------------------------------------------------------------
module udp_receive_dispatcher
  import udp_receive_package::*;
#(
  parameter int SLOT_COUNT = SLOT_COUNT_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [7:0]            data,
  input  logic                  data_valid,
  input  logic                  packet_start,
  input  logic                  packet_end,
  input  logic                  packet_error,
  input  logic [15:0]           ipv4_flags,
  input  logic [15:0]           ipv4_identification,
  input  logic [SLOT_COUNT-1:0] slot_ready,
  output logic [7:0]            slot_data,
  output logic [SLOT_COUNT-1:0] slot_data_enable,
  output logic [SLOT_COUNT-1:0] slot_good_packet,
  output logic [SLOT_COUNT-1:0] slot_bad_packet,
  output logic [15:0]           slot_ipv4_flags,
  output logic [15:0]           slot_ipv4_identification,
  output logic                  dropped_packet,
  output logic [15:0]           drop_count
);

  state_t                      state_q, state_d;
  logic [SLOT_COUNT-1:0]       sel_q, sel_d;
  logic [SLOT_INDEX_WIDTH-1:0] pointer_q, pointer_d;
  logic [SLOT_COUNT-1:0]       enable_q, enable_d;
  logic [SLOT_COUNT-1:0]       good_pend_q, good_pend_d;
  logic [SLOT_COUNT-1:0]       bad_pend_q, bad_pend_d;
  logic [SLOT_COUNT-1:0]       abort_bad_d;
  logic [SLOT_COUNT-1:0]       good_q, bad_q;
  logic [7:0]                  data_q;
  logic [15:0]                 flags_q, ident_q;
  logic                        dropped_q;
  logic [15:0]                 drop_count_q, drop_count_d;
  logic [1:0]                  drop_inc;
  logic [16:0]                 drop_sum;
  logic                        begin_packet;
  logic                        capture;

  logic [SLOT_COUNT-1:0]       request;
  logic [SLOT_COUNT-1:0]       grant;
  logic                        grant_valid;

  // A restart inside a packet must not hand the new packet to the slot that
  // is being aborted.
  assign request = slot_ready & ~((state_q == S_FORWARD) ? sel_q : '0);

  round_robin_selector #(.SLOT_COUNT(SLOT_COUNT)) u_selector (
    .request_i     (request),
    .pointer_i     (pointer_q),
    .grant_o       (grant),
    .grant_valid_o (grant_valid)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d      = state_q;
    sel_d        = sel_q;
    pointer_d    = pointer_q;
    enable_d     = '0;
    good_pend_d  = '0;
    bad_pend_d   = '0;
    abort_bad_d  = '0;
    drop_inc     = 2'd0;
    begin_packet = 1'b0;
    capture      = 1'b0;

    if (data_valid) begin
      unique case (state_q)
        S_IDLE: begin
          begin_packet = packet_start;
        end
        S_FORWARD: begin
          if (packet_start) begin
            // Missing end: reject the old packet at once, so its pulse can
            // never coincide with a single-byte new packet's completion.
            abort_bad_d  = sel_q;
            begin_packet = 1'b1;
          end else begin
            enable_d = sel_q;
            if (packet_end) begin
              if (packet_error) bad_pend_d  = sel_q;
              else              good_pend_d = sel_q;
              state_d = S_IDLE;
            end
          end
        end
        S_DISCARD: begin
          if (packet_start) begin
            drop_inc     = 2'd1;
            begin_packet = 1'b1;
          end else if (packet_end) begin
            drop_inc = 2'd1;
            state_d  = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (begin_packet) begin
      if (grant_valid) begin
        sel_d     = grant;
        pointer_d = onehot_to_index(8'(grant));
        enable_d  = grant;
        capture   = 1'b1;
        if (packet_end) begin
          if (packet_error) bad_pend_d  = grant;
          else              good_pend_d = grant;
          state_d = S_IDLE;
        end else begin
          state_d = S_FORWARD;
        end
      end else if (packet_end) begin
        drop_inc = drop_inc + 2'd1;
        state_d  = S_IDLE;
      end else begin
        state_d = S_DISCARD;
      end
    end
  end

  assign drop_sum     = {1'b0, drop_count_q} + 17'(drop_inc);
  assign drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

  // NOTE: reset is asynchronous; a packet in flight is simply forgotten.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      sel_q        <= '0;
      pointer_q    <= SLOT_INDEX_WIDTH'(SLOT_COUNT - 1);
      enable_q     <= '0;
      good_pend_q  <= '0;
      bad_pend_q   <= '0;
      good_q       <= '0;
      bad_q        <= '0;
      data_q       <= '0;
      flags_q      <= '0;
      ident_q      <= '0;
      dropped_q    <= 1'b0;
      drop_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      sel_q        <= sel_d;
      pointer_q    <= pointer_d;
      enable_q     <= enable_d;
      good_pend_q  <= good_pend_d;
      bad_pend_q   <= bad_pend_d;
      // Completions go through one extra stage so they follow the final enable.
      good_q       <= good_pend_q;
      bad_q        <= bad_pend_q | abort_bad_d;
      dropped_q    <= (drop_inc != 2'd0);
      drop_count_q <= drop_count_d;
      if (|enable_d) data_q <= data;
      if (capture) begin
        flags_q <= ipv4_flags;
        ident_q <= ipv4_identification;
      end
    end
  end

  assign slot_data                = data_q;
  assign slot_data_enable         = enable_q;
  assign slot_good_packet         = good_q;
  assign slot_bad_packet          = bad_q;
  assign slot_ipv4_flags          = flags_q;
  assign slot_ipv4_identification = ident_q;
  assign dropped_packet           = dropped_q;
  assign drop_count               = drop_count_q;

endmodule

// File: tb/tb_udp_receive_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_udp_receive_dispatcher
// Directed stimulus pushes hand-derived expectations (cycle, slot, byte, header
// fields, completion kind, drop count) into queues; a monitor on the falling
// edge pops and compares whenever the dispatcher presents an output.
// -----------------------------------------------------------------------------
module tb_udp_receive_dispatcher;

  localparam int N = 4;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [7:0]   data;
  logic         data_valid;
  logic         packet_start;
  logic         packet_end;
  logic         packet_error;
  logic [15:0]  ipv4_flags;
  logic [15:0]  ipv4_identification;
  logic [N-1:0] slot_ready;
  logic [7:0]   slot_data;
  logic [N-1:0] slot_data_enable;
  logic [N-1:0] slot_good_packet;
  logic [N-1:0] slot_bad_packet;
  logic [15:0]  slot_ipv4_flags;
  logic [15:0]  slot_ipv4_identification;
  logic         dropped_packet;
  logic [15:0]  drop_count;

  udp_receive_dispatcher #(.SLOT_COUNT(N)) dut (
    .clock                    (clock),
    .reset_n                  (reset_n),
    .data                     (data),
    .data_valid               (data_valid),
    .packet_start             (packet_start),
    .packet_end               (packet_end),
    .packet_error             (packet_error),
    .ipv4_flags               (ipv4_flags),
    .ipv4_identification      (ipv4_identification),
    .slot_ready               (slot_ready),
    .slot_data                (slot_data),
    .slot_data_enable         (slot_data_enable),
    .slot_good_packet         (slot_good_packet),
    .slot_bad_packet          (slot_bad_packet),
    .slot_ipv4_flags          (slot_ipv4_flags),
    .slot_ipv4_identification (slot_ipv4_identification),
    .dropped_packet           (dropped_packet),
    .drop_count               (drop_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [N-1:0] slot;
    logic [7:0]   data;
    logic [15:0]  flags;
    logic [15:0]  id;
  } en_rec_t;

  typedef struct {
    int           cyc;
    logic [N-1:0] slot;
    logic         bad;
  } end_rec_t;

  typedef struct {
    int cyc;
    int count;
  } drop_rec_t;

  en_rec_t   en_exp[$];
  end_rec_t  end_exp[$];
  drop_rec_t drop_exp[$];
  en_rec_t   er;
  end_rec_t  nr;
  drop_rec_t dr;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every presented output against the head of its queue.
  always @(negedge clock) begin
    if (reset_n) begin
      if (slot_data_enable != '0) begin
        check("enable_onehot", 32'($onehot(slot_data_enable)), 32'd1);
        if (en_exp.size() == 0) begin
          check("enable_unexpected", 32'(slot_data_enable), 32'd0);
        end else begin
          er = en_exp.pop_front();
          check("enable_cycle", cyc, er.cyc);
          check("enable_slot", 32'(slot_data_enable), 32'(er.slot));
          check("enable_data", 32'(slot_data), 32'(er.data));
          check("held_flags", 32'(slot_ipv4_flags), 32'(er.flags));
          check("held_ident", 32'(slot_ipv4_identification), 32'(er.id));
        end
      end
      if ((slot_good_packet | slot_bad_packet) != '0) begin
        check("completion_onehot", 32'($onehot({slot_good_packet, slot_bad_packet})), 32'd1);
        if (end_exp.size() == 0) begin
          check("completion_unexpected", 32'({slot_good_packet, slot_bad_packet}), 32'd0);
        end else begin
          nr = end_exp.pop_front();
          check("completion_cycle", cyc, nr.cyc);
          check("completion_slot", 32'(slot_good_packet | slot_bad_packet), 32'(nr.slot));
          check("completion_kind", 32'({|slot_bad_packet, |slot_good_packet}),
                nr.bad ? 32'd2 : 32'd1);
        end
      end
      if (dropped_packet) begin
        if (drop_exp.size() == 0) begin
          check("drop_unexpected", 32'(dropped_packet), 32'd0);
        end else begin
          dr = drop_exp.pop_front();
          check("drop_cycle", cyc, dr.cyc);
          check("drop_count", 32'(drop_count), dr.count);
        end
      end
    end
  end

  task automatic clear_inputs();
    data_valid          = 1'b0;
    packet_start        = 1'b0;
    packet_end          = 1'b0;
    packet_error        = 1'b0;
    data                = 8'hEE;
    ipv4_flags          = 16'h0;
    ipv4_identification = 16'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      clear_inputs();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_enable"}, 32'(slot_data_enable), 32'd0);
    check({tag, "_good"}, 32'(slot_good_packet), 32'd0);
    check({tag, "_bad"}, 32'(slot_bad_packet), 32'd0);
    check({tag, "_data"}, 32'(slot_data), 32'd0);
    check({tag, "_flags"}, 32'(slot_ipv4_flags), 32'd0);
    check({tag, "_ident"}, 32'(slot_ipv4_identification), 32'd0);
    check({tag, "_dropped"}, 32'(dropped_packet), 32'd0);
    check({tag, "_drop_count"}, 32'(drop_count), 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    clear_inputs();
    slot_ready = '0;
    #2;
    check_all_zero("reset");
    @(negedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // Drives one packet; exp_slot < 0 means it must be discarded. abort_slot /
  // abort_drops describe what the start byte does to a packet already open.
  task automatic send_packet(input int len, input logic [7:0] d0, input logic [15:0] flags,
                             input logic [15:0] id, input logic [N-1:0] ready, input logic err,
                             input bit with_end, input bit gaps, input int exp_slot,
                             input int exp_drops, input int abort_slot, input int abort_drops);
    for (int i = 0; i < len; i++) begin
      if (gaps && (i % 2 == 1)) begin
        @(negedge clock);
        clear_inputs();
      end
      @(negedge clock);
      data_valid          = 1'b1;
      data                = d0 + 8'(i);
      packet_start        = (i == 0);
      packet_end          = with_end && (i == len - 1);
      packet_error        = err && packet_end;
      ipv4_flags          = (i == 0) ? flags : 16'hDEAD;
      ipv4_identification = (i == 0) ? id : 16'hBEEF;
      // Ready drops after the start byte; the chosen slot must stay selected.
      slot_ready          = (i == 0) ? ready : '0;
      if (i == 0 && abort_slot >= 0) end_exp.push_back('{cyc + 1, N'(1 << abort_slot), 1'b1});
      if (i == 0 && abort_drops > 0) drop_exp.push_back('{cyc + 1, abort_drops});
      if (exp_slot >= 0) begin
        en_exp.push_back('{cyc + 1, N'(1 << exp_slot), d0 + 8'(i), flags, id});
        if (packet_end) end_exp.push_back('{cyc + 2, N'(1 << exp_slot), err});
      end else if (packet_end) begin
        drop_exp.push_back('{cyc + 1, exp_drops});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1;
    clear_inputs();
    slot_ready = '0;
    apply_reset();

    // 4-byte packet after reset goes to slot 0, good completion.
    send_packet(4, 8'h10, 16'h4000, 16'hA5A5, 4'b1111, 1'b0, 1'b1, 1'b0, 0, 0, -1, 0);
    idle(4);

    // Three back-to-back packets from reset: slots 0, 1, 2.
    apply_reset();
    send_packet(3, 8'h20, 16'h0001, 16'h1111, 4'b1111, 1'b0, 1'b1, 1'b0, 0, 0, -1, 0);
    send_packet(2, 8'h30, 16'h0002, 16'h2222, 4'b1111, 1'b0, 1'b1, 1'b1, 1, 0, -1, 0);
    send_packet(3, 8'h40, 16'h0003, 16'h3333, 4'b1111, 1'b0, 1'b1, 1'b0, 2, 0, -1, 0);
    idle(4);

    // No slot ready: 10-byte packet dropped, count 1.
    send_packet(10, 8'h50, 16'h0, 16'h0, 4'b0000, 1'b0, 1'b1, 1'b1, -1, 1, -1, 0);
    idle(3);

    // Errored packet: round robin continues to slot 3, bad completion.
    send_packet(3, 8'h60, 16'h2000, 16'h4444, 4'b1111, 1'b1, 1'b1, 1'b0, 3, 0, -1, 0);
    idle(4);

    // Restart mid-packet on slot 0 with only slots 0/1 ready.
    apply_reset();
    send_packet(3, 8'h70, 16'h0005, 16'h5555, 4'b0011, 1'b0, 1'b0, 1'b0, 0, 0, -1, 0);
    send_packet(2, 8'h80, 16'h0006, 16'h6666, 4'b0011, 1'b0, 1'b1, 1'b0, 1, 0, 0, 0);
    idle(4);

    // Restart while discarding: old packet counted, new one to slot 2.
    send_packet(2, 8'h90, 16'h0, 16'h0, 4'b0000, 1'b0, 1'b0, 1'b0, -1, 0, -1, 0);
    send_packet(2, 8'hA0, 16'h0007, 16'h7777, 4'b1111, 1'b0, 1'b1, 1'b0, 2, 0, -1, 1);
    idle(4);

    // Single-byte packet, then reset in the middle of the next packet.
    apply_reset();
    send_packet(1, 8'hB0, 16'h0008, 16'h8888, 4'b1111, 1'b0, 1'b1, 1'b0, 0, 0, -1, 0);
    send_packet(3, 8'hC0, 16'h0009, 16'h9999, 4'b1111, 1'b0, 1'b0, 1'b0, 1, 0, -1, 0);
    apply_reset();
    // Stray bytes without a start marker must be ignored.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      data_valid = 1'b1;
      data       = 8'hD0 + 8'(i);
      packet_end = (i == 3);
      slot_ready = 4'b1111;
    end
    idle(3);
    check_all_zero("post_reset");
    // Round robin restarts at slot 0 after reset.
    send_packet(2, 8'hE0, 16'h000A, 16'hAAAA, 4'b1111, 1'b0, 1'b1, 1'b0, 0, 0, -1, 0);
    idle(5);

    check("en_queue_drained", en_exp.size(), 32'd0);
    check("end_queue_drained", end_exp.size(), 32'd0);
    check("drop_queue_drained", drop_exp.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/udp_receive_dispatcher.md
UDP_RECEIVE_DISPATCHER -- requirements
Module: udp_receive_dispatcher

Interface
REQ-001 Parameter SLOT_COUNT, default 4: number of downstream receive_slot instances served (2..8).
REQ-002 clock  input  1  single clock domain, all logic rising-edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 data  input  8  UDP payload byte from parser.
REQ-005 data_valid  input  1  data qualifier; gaps allowed anywhere in a packet.
REQ-006 packet_start  input  1  first payload byte marker, qualified by data_valid.
REQ-007 packet_end  input  1  last payload byte marker, qualified by data_valid.
REQ-008 packet_error  input  1  checksum/length error, sampled only with packet_end.
REQ-009 ipv4_flags  input  16  valid when packet_start & data_valid.
REQ-010 ipv4_identification  input  16  valid when packet_start & data_valid.
REQ-011 slot_ready  input  SLOT_COUNT  per-slot idle/ready from receive slots.
REQ-012 slot_data  output  8  registered byte, common to all slots.
REQ-013 slot_data_enable  output  SLOT_COUNT  one-hot write enable to selected slot.
REQ-014 slot_good_packet  output  SLOT_COUNT  one-cycle pulse, packet accepted.
REQ-015 slot_bad_packet  output  SLOT_COUNT  one-cycle pulse, packet rejected.
REQ-016 slot_ipv4_flags  output  16  captured flags, held stable for whole packet.
REQ-017 slot_ipv4_identification  output  16  captured identification, held stable.
REQ-018 dropped_packet  output  1  one-cycle pulse when a packet is discarded for lack of a slot.
REQ-019 drop_count  output  16  saturating count of dropped packets.

Function
REQ-020 FSM states S_IDLE, S_FORWARD, S_DISCARD; reset state S_IDLE.
REQ-021 S_IDLE, data_valid & packet_start: select next ready slot round-robin, starting one above last granted index and wrapping modulo SLOT_COUNT; capture flags/identification; go to S_FORWARD.
REQ-022 No slot ready at packet_start: go to S_DISCARD; no slot_data_enable asserted.
REQ-023 S_FORWARD: each data_valid byte produces slot_data and slot_data_enable[sel], registered exactly 1 cycle later.
REQ-024 packet_end in S_FORWARD: slot_good_packet[sel] (no error) or slot_bad_packet[sel] (error) pulses in the cycle after the final byte's enable (2 cycles after input); return to S_IDLE.
REQ-025 packet_end in S_DISCARD: dropped_packet pulses 1 cycle later; drop_count increments, saturating at 0xFFFF; return to S_IDLE.
REQ-026 Single-byte packet (packet_start & packet_end same cycle): complete start+end handling; FSM stays in S_IDLE.
REQ-027 packet_start while in S_FORWARD (missing end): pulse slot_bad_packet on old slot, then handle the byte as a new start per REQ-021, excluding the old slot.
REQ-028 packet_start while in S_DISCARD: count the old packet as dropped, then handle per REQ-021.
REQ-029 Bytes with data_valid in S_IDLE without packet_start: ignored.
REQ-030 slot_ready is sampled only at packet_start; deassertion mid-packet has no effect.
REQ-031 At most one bit of slot_data_enable, slot_good_packet and slot_bad_packet is high per cycle; good and bad are never high together.

Reset
REQ-032 Reset: all outputs 0, drop_count 0, round-robin pointer at SLOT_COUNT-1 so slot 0 is granted first.
REQ-033 Reset mid-packet: the packet is lost without a good/bad pulse; after release, bytes are ignored until the next packet_start.

Structure
REQ-034 State enum and SLOT_COUNT default live in shared package udp_receive_package.
REQ-035 Slot selection is one sub-module, round_robin_selector (combinational: request, pointer -> one-hot grant, grant_valid).

Verification
REQ-036 4-byte packet, slot_ready=4'b1111 after reset -> slot 0 gets 4 enables 1 cycle delayed, then slot_good_packet[0] one cycle after last enable.
REQ-037 Three back-to-back packets, all ready -> grants to slots 0, 1, 2 in order; identification values 0x1111, 0x2222, 0x3333 held correctly.
REQ-038 slot_ready=4'b0000, 10-byte packet -> no enables; dropped_packet pulse; drop_count=1.
REQ-039 Packet with packet_error on end -> slot_bad_packet pulses; slot_good_packet stays 0.
REQ-040 packet_start mid-packet on slot 0, slot_ready=4'b0011 -> slot_bad_packet[0] pulses; new packet goes to slot 1.
REQ-041 Single-byte packet, then reset asserted mid-packet -> first gives 1 enable plus good pulse; after reset, all outputs are 0 and stray bytes are ignored.
